// File: rtl/firbank_pkg.sv
// Shared types and helpers for the multi-channel FIR bank.
// Holds parameter defaults, FSM encoding, clog2 and round/saturate.
package firbank_pkg;

   localparam int NCH_DEF    = 8;
   localparam int NTAPS_DEF  = 128;
   localparam int DW_DEF     = 16;
   localparam int CW_DEF     = 18;
   localparam int OSHIFT_DEF = 16;
   localparam int SAT_DEF    = 1;

   localparam int RSW = 128;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SHIFT,
      S_MAC,
      S_DRAIN,
      S_OUT
   } state_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < n) r = i + 1;
      return r;
   endfunction

   // Round half up at bit oshift, then optionally clamp to dw signed bits.
   function automatic logic signed [RSW-1:0] round_sat(
      input logic signed [RSW-1:0] acc,
      input int                    oshift,
      input int                    dw,
      input int                    sat
   );
      logic signed [RSW-1:0] r;
      logic signed [RSW-1:0] q;
      logic signed [RSW-1:0] hi;
      logic signed [RSW-1:0] lo;
      r  = acc + $signed(RSW'(1) << (oshift - 1));
      q  = r >>> oshift;
      hi = $signed((RSW'(1) << (dw - 1)) - RSW'(1));
      lo = -hi - 1;
      if (sat != 0) begin
         if (q > hi)      q = hi;
         else if (q < lo) q = lo;
      end
      return q;
   endfunction

endpackage

// File: rtl/firbank_mac.sv
// One channel of the FIR bank: coefficient pair register,
// two multipliers, wide accumulator and output rounding.
module firbank_mac
   import firbank_pkg::*;
#(
   parameter int NTAPS  = NTAPS_DEF,
   parameter int DW     = DW_DEF,
   parameter int CW     = CW_DEF,
   parameter int OSHIFT = OSHIFT_DEF,
   parameter int SAT    = SAT_DEF
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            clear,
   input  logic            load,
   input  logic            mul,
   input  logic            acc_en,
   input  logic            out_en,
   input  logic [2*CW-1:0] coeff,
   input  logic [DW-1:0]   x_even,
   input  logic [DW-1:0]   x_odd,
   output logic [DW-1:0]   dataout
);

   localparam int PW   = DW + CW;
   localparam int ACCW = DW + CW + clog2(NTAPS);

   logic signed [CW-1:0]   c_even;
   logic signed [CW-1:0]   c_odd;
   logic signed [PW-1:0]   p_even;
   logic signed [PW-1:0]   p_odd;
   logic signed [ACCW-1:0] acc;

   always_ff @(posedge clock) begin
      if (reset) begin
         c_even  <= '0;
         c_odd   <= '0;
         p_even  <= '0;
         p_odd   <= '0;
         acc     <= '0;
         dataout <= '0;
      end else begin
         if (load) begin
            c_even <= $signed(coeff[CW-1:0]);
            c_odd  <= $signed(coeff[2*CW-1:CW]);
         end
         if (mul) begin
            p_even <= PW'($signed(x_even)) * PW'(c_even);
            p_odd  <= PW'($signed(x_odd)) * PW'(c_odd);
         end
         if (clear)
            acc <= '0;
         else if (acc_en)
            acc <= acc + ACCW'(p_even) + ACCW'(p_odd);
         if (out_en)
            dataout <= DW'(round_sat(RSW'(acc), OSHIFT, DW, SAT));
      end
   end

endmodule

// File: rtl/firbank_param.sv
// Multi-channel FIR bank: shared delay line, sequencing FSM and
// the sample-pair pipeline feeding NCH firbank_mac channels.
module firbank_param
   import firbank_pkg::*;
#(
   parameter int NCH    = NCH_DEF,
   parameter int NTAPS  = NTAPS_DEF,
   parameter int DW     = DW_DEF,
   parameter int CW     = CW_DEF,
   parameter int OSHIFT = OSHIFT_DEF,
   parameter int SAT    = SAT_DEF,
   localparam int AW    = clog2(NTAPS / 2)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [DW-1:0]       datain,
   input  logic                din_enable,
   output logic                din_ready,
   output logic [AW-1:0]       coeffaddress,
   input  logic [NCH*2*CW-1:0] coeff,
   output logic [NCH*DW-1:0]   dataout,
   output logic                dout_valid,
   output logic                overrun
);

   localparam logic [AW-1:0] LAST = AW'(NTAPS / 2 - 1);

   state_t        state;
   logic [1:0]    drain_cnt;
   logic [DW-1:0] dline [NTAPS];
   logic [AW-1:0] pair_q;
   logic          v1;
   logic          v2;
   logic          v3;
   logic [DW-1:0] x_even;
   logic [DW-1:0] x_odd;
   logic          clear;
   logic          out_en;

   assign din_ready = (state == S_IDLE);
   assign clear     = din_ready & din_enable;
   assign out_en    = (state == S_OUT);

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= S_IDLE;
         coeffaddress <= '0;
         drain_cnt    <= '0;
         pair_q       <= '0;
         v1           <= 1'b0;
         dout_valid   <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         dout_valid <= 1'b0;
         v1         <= 1'b0;
         if (din_enable && !din_ready)
            overrun <= 1'b1;
         unique case (state)
            S_IDLE: begin
               if (din_enable) begin
                  state        <= S_SHIFT;
                  coeffaddress <= '0;
               end
            end
            S_SHIFT: begin
               state        <= S_MAC;
               coeffaddress <= '0;
            end
            S_MAC: begin
               v1     <= 1'b1;
               pair_q <= coeffaddress;
               if (coeffaddress == LAST) begin
                  coeffaddress <= '0;
                  drain_cnt    <= 2'd2;
                  state        <= S_DRAIN;
               end else begin
                  coeffaddress <= coeffaddress + 1'b1;
               end
            end
            S_DRAIN: begin
               if (drain_cnt == 2'd0)
                  state <= S_OUT;
               else
                  drain_cnt <= drain_cnt - 1'b1;
            end
            S_OUT: begin
               dout_valid <= 1'b1;
               state      <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Index 0 holds the newest sample; the line only moves on acceptance.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NTAPS; i++)
            dline[i] <= '0;
      end else if (clear) begin
         dline[0] <= datain;
         for (int i = 1; i < NTAPS; i++)
            dline[i] <= dline[i-1];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         v2     <= 1'b0;
         v3     <= 1'b0;
         x_even <= '0;
         x_odd  <= '0;
      end else begin
         v2 <= v1;
         v3 <= v2;
         if (v1) begin
            x_even <= dline[{pair_q, 1'b0}];
            x_odd  <= dline[{pair_q, 1'b1}];
         end
      end
   end

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      firbank_mac #(
         .NTAPS  (NTAPS),
         .DW     (DW),
         .CW     (CW),
         .OSHIFT (OSHIFT),
         .SAT    (SAT)
      ) u_mac (
         .clock   (clock),
         .reset   (reset),
         .clear   (clear),
         .load    (v1),
         .mul     (v2),
         .acc_en  (v3),
         .out_en  (out_en),
         .coeff   (coeff[c*2*CW +: 2*CW]),
         .x_even  (x_even),
         .x_odd   (x_odd),
         .dataout (dataout[c*DW +: DW])
      );
   end

endmodule

// File: tb/tb_firbank_param.sv
// Directed bench for firbank_param: default, SAT=0 and a
// 2-channel 4-tap instance against hand-computed results.
module tb_firbank_param;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc++;

   logic [15:0]  din_a = '0;
   logic         en_a  = 1'b0;
   logic [287:0] coeff_a;
   logic         rdy_a, dv_a, ovr_a;
   logic [5:0]   ca_a;
   logic [127:0] do_a;
   logic         rdy_b, dv_b, ovr_b;
   logic [5:0]   ca_b;
   logic [127:0] do_b;

   logic [15:0]  din_c = '0;
   logic         en_c  = 1'b0;
   logic [71:0]  coeff_c;
   logic         rdy_c, dv_c, ovr_c;
   logic [0:0]   ca_c;
   logic [31:0]  do_c;

   int ha [8][128];
   int hc [2][4];

   always @(posedge clock) begin
      logic [287:0] w;
      w = '0;
      for (int c = 0; c < 8; c++) begin
         w[c*36 +: 18]    = 18'(ha[c][2*ca_a]);
         w[c*36+18 +: 18] = 18'(ha[c][2*ca_a+1]);
      end
      coeff_a <= w;
   end

   always @(posedge clock) begin
      logic [71:0] w;
      w = '0;
      for (int c = 0; c < 2; c++) begin
         w[c*36 +: 18]    = 18'(hc[c][2*ca_c]);
         w[c*36+18 +: 18] = 18'(hc[c][2*ca_c+1]);
      end
      coeff_c <= w;
   end

   firbank_param u_dut_a (
      .clock(clock), .reset(reset), .datain(din_a), .din_enable(en_a),
      .din_ready(rdy_a), .coeffaddress(ca_a), .coeff(coeff_a),
      .dataout(do_a), .dout_valid(dv_a), .overrun(ovr_a)
   );

   firbank_param #(.SAT(0)) u_dut_b (
      .clock(clock), .reset(reset), .datain(din_a), .din_enable(en_a),
      .din_ready(rdy_b), .coeffaddress(ca_b), .coeff(coeff_a),
      .dataout(do_b), .dout_valid(dv_b), .overrun(ovr_b)
   );

   firbank_param #(.NCH(2), .NTAPS(4)) u_dut_c (
      .clock(clock), .reset(reset), .datain(din_c), .din_enable(en_c),
      .din_ready(rdy_c), .coeffaddress(ca_c), .coeff(coeff_c),
      .dataout(do_c), .dout_valid(dv_c), .overrun(ovr_c)
   );

   int checks = 0;
   int errors = 0;
   int t_acc  = 0;

   task automatic check(input string tag, input logic [127:0] got,
                        input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic send(input bit to_c, input logic [15:0] s);
      @(negedge clock);
      if (to_c) begin
         din_c = s;
         en_c  = 1'b1;
      end else begin
         din_a = s;
         en_a  = 1'b1;
      end
      @(posedge clock);
      #1;
      t_acc = cyc;
      en_a  = 1'b0;
      en_c  = 1'b0;
   endtask

   task automatic wait_out(input bit to_c, input string tag, input int lat);
      int n;
      bit got;
      bit got_b;
      n     = 0;
      got   = 1'b0;
      got_b = 1'b0;
      while (!got && n < 300) begin
         @(negedge clock);
         n++;
         got   = to_c ? dv_c : dv_a;
         got_b = dv_b;
      end
      check({tag, "_lat"}, 128'(cyc - t_acc), 128'(lat));
      if (!to_c) check({tag, "_b_valid"}, 128'(got_b), 128'd1);
      @(negedge clock);
      check({tag, "_pulse"}, 128'(to_c ? dv_c : dv_a), 128'd0);
   endtask

   initial begin
      int nv;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      check("rst_ready", 128'(rdy_a), 128'd1);
      check("rst_valid", 128'(dv_a), 128'd0);
      check("rst_overrun", 128'(ovr_a), 128'd0);
      check("rst_addr", 128'(ca_a), 128'd0);
      check("rst_dout", do_a, 128'd0);
      check("rst_dout_c", 128'(do_c), 128'd0);

      for (int i = 0; i < 3; i++) begin
         send(1'b0, 16'h7fff);
         if (i == 0) check("zero_busy", 128'(rdy_a), 128'd0);
         wait_out(1'b0, "zero", 69);
         check("zero_out", do_a, 128'd0);
      end

      do_reset();
      ha[0][0] = 4;
      ha[0][1] = 8;
      send(1'b0, 16'h4000);
      wait_out(1'b0, "imp1", 69);
      check("imp1_a", do_a, 128'd1);
      check("imp1_b", do_b, 128'd1);
      send(1'b0, 16'h0000);
      wait_out(1'b0, "imp2", 69);
      check("imp2_a", do_a, 128'd2);
      check("imp_overrun", 128'(ovr_a), 128'd0);

      do_reset();
      ha[0][0] = 0;
      ha[0][1] = 0;
      ha[1][0] = 131071;
      send(1'b0, 16'h7fff);
      wait_out(1'b0, "sat_hi", 69);
      check("sat_hi_a", do_a, 128'h7fff_0000);
      check("sat_hi_b", do_b, 128'hfffe_0000);
      send(1'b0, 16'h8000);
      wait_out(1'b0, "sat_lo", 69);
      check("sat_lo_a", do_a, 128'h8000_0000);
      check("sat_lo_b", do_b, 128'h0001_0000);

      do_reset();
      ha[1][0] = 0;
      ha[0][0] = 4;
      ha[0][1] = 8;
      send(1'b0, 16'h4000);
      repeat (10) @(negedge clock);
      din_a = 16'h1234;
      en_a  = 1'b1;
      @(posedge clock);
      #1;
      en_a = 1'b0;
      check("ovr_flag", 128'(ovr_a), 128'd1);
      check("ovr_busy", 128'(rdy_a), 128'd0);
      wait_out(1'b0, "ovr", 69);
      check("ovr_out", do_a, 128'd1);
      send(1'b0, 16'h0000);
      wait_out(1'b0, "ovr_next", 69);
      check("ovr_next_out", do_a, 128'd2);

      send(1'b0, 16'h4000);
      repeat (29) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("mid_ready", 128'(rdy_a), 128'd1);
      check("mid_dout", do_a, 128'd0);
      check("mid_overrun", 128'(ovr_a), 128'd0);
      check("mid_addr", 128'(ca_a), 128'd0);
      nv = 0;
      repeat (100) begin
         @(negedge clock);
         if (dv_a) nv++;
      end
      check("mid_novalid", 128'(nv), 128'd0);

      for (int c = 0; c < 2; c++)
         for (int t = 0; t < 4; t++)
            hc[c][t] = 4 * (t + 1);
      for (int k = 1; k <= 4; k++) begin
         send(1'b1, (k == 1) ? 16'h4000 : 16'h0000);
         wait_out(1'b1, "small", 7);
         check("small_out", 128'(do_c), 128'({16'(k), 16'(k)}));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
